onoff_cmd_driver: RTL and testbench
===================================

# onoff_cmd_driver

- Command-side driver for the two-state ON/OFF J/K follower FSM used elsewhere in the design.
- Accepts a requested level over a valid/ready handshake and issues single-cycle `j` (turn ON) or `k` (turn OFF) pulses to the follower.
- Watches the follower's status output until it matches the request, retrying on timeout.
- Reports completion with a one-cycle `done` pulse, or failure with a one-cycle `err` pulse.

## Interface
- `TIMEOUT`, 8: WAIT cycles allowed per pulse before a retry; legal range ≥1.
- `RETRIES`, 2: extra pulses after the first; total pulses = RETRIES+1; legal range ≥0.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_on`  in  1  requested level: 1 = ON, 0 = OFF; sampled on accept.
- `req_ready`  out  1  high only in IDLE.
- `status`  in  1  follower's `out` (1 = ON).
- `j`  out  1  set pulse to follower.
- `k`  out  1  clear pulse to follower.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: status reached the target.
- `err`  out  1  one-cycle pulse: retries exhausted.

## Operation
- States: IDLE, DRIVE, WAIT, DONE, ERR. All outputs are Moore decodes of registered state and the latched target.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_on` into `target` and clear the retry counter.
  - If synced status == `req_on`, go to DONE; no pulse is issued.
  - Otherwise go to DRIVE.
- **DRIVE**
  - Lasts exactly one cycle.
  - `j`=target, `k`=~target.
  - Loads timer = TIMEOUT-1, then goes to WAIT.
- **WAIT**
  - If synced status == target, go to DONE.
  - Else, if timer != 0, decrement the timer.
  - Else, if retry count < RETRIES, increment the retry count and go to DRIVE.
  - Else go to ERR.
  - A status match in the same cycle the timer expires takes priority: go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **ERR**
  - `err`=1 for one cycle, then go to IDLE.
- `j` and `k` are never high together; both are 0 outside DRIVE.
- `req_valid` is ignored while `busy`; requests are not queued.
- Status changes after DONE are not monitored.
- Counter widths: timer `$clog2(TIMEOUT+1)`, retry counter `$clog2(RETRIES+1)`, each minimum 1 bit. Counters never wrap.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `j`=0, `k`=0, `done`=0, `err`=0, `target`=0, counters 0. Sync flops (when enabled) reset to 0.
- Reset mid-operation: outputs return to reset values asynchronously. Any pulse in flight is truncated. No `done` or `err` is emitted.
- Nominal latency with the follower responding in one cycle and sync disabled:
  - cycle 0: accept.
  - cycle 1: DRIVE, pulse on `j` or `k`.
  - cycle 2: WAIT, status matches.
  - cycle 3: `done`=1.
  - cycle 4: `req_ready`=1.
- Already-at-target request: accept in cycle 0, `done` in cycle 1, no pulse.
- Worst case: (RETRIES+1)×(1+TIMEOUT) cycles from accept to ERR, then `err` the next cycle.

## Configuration
- `ONOFF_STATUS_SYNC_EN`
  - Defined: `status` passes through a 2-flop synchronizer before every compare in IDLE and WAIT. Nominal latency grows by 2 cycles (`done` at cycle 5). TIMEOUT must cover the added delay.
  - Undefined: `status` is used directly (same-clock follower).

## Test plan
- Defaults, follower model connected, status=0. Request req_on=1 → `j`=1 for one cycle at cycle 1, `k` stays 0, `done` at cycle 3, `req_ready` back at cycle 4.
- Status=1. Request req_on=1 → no `j`/`k` pulse, `done` at cycle 1.
- Status held at 0. Request ON with TIMEOUT=8, RETRIES=2 → exactly 3 `j` pulses spaced 9 cycles apart, `err` 1 cycle after the 27th post-accept cycle, `done` never asserted.
- Follower ignores the first pulse and responds to the second → 2 `k` pulses, then `done`, no `err`.
- Assert `rst` low during WAIT, then `req_valid` held high while busy → outputs go to reset values immediately. Held requests are not accepted until IDLE. After reset release, a fresh request completes normally.
- Status reaches target in the cycle the timer hits 0 → `done` asserted, no further DRIVE pulse.

Source files
------------

// File: rtl/onoff_cmd_driver.sv
// Command-side driver for the ON/OFF J/K follower: pulses j/k, watches status, retries on timeout.
// Optional build macro ONOFF_STATUS_SYNC_EN inserts a 2-flop synchronizer on status_i.
module onoff_cmd_driver #(
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned RETRIES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_valid_i,
   input  logic req_on_i,
   output logic req_ready_o,
   input  logic status_i,
   output logic j_o,
   output logic k_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);

   localparam int unsigned TimerW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned RetryW = ($clog2(RETRIES + 1) > 1) ? $clog2(RETRIES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_e;

   state_e              state_q, state_d;
   logic                target_q, target_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [RetryW-1:0]   retry_q, retry_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;
   logic                j_q, j_d;
   logic                k_q, k_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                status_s;

`ifdef ONOFF_STATUS_SYNC_EN
   logic [1:0] sync_q;

   // Two-stage synchronizer for an asynchronous follower.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], status_i};
      end
   end

   assign status_s = sync_q[1];
`else
   assign status_s = status_i;
`endif

   // Next-state and next-output logic; outputs registered from the next state.
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      timer_d     = timer_q;
      retry_d     = retry_q;
      req_ready_d = 1'b0;
      busy_d      = 1'b0;
      j_d         = 1'b0;
      k_d         = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               target_d = req_on_i;
               retry_d  = '0;
               state_d  = (status_s == req_on_i) ? S_DONE : S_DRIVE;
            end
         end
         S_DRIVE: begin
            timer_d = TimerW'(TIMEOUT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A match wins over timer expiry in the same cycle.
            if (status_s == target_q) begin
               state_d = S_DONE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TimerW'(1);
            end else if (retry_q < RetryW'(RETRIES)) begin
               retry_d = retry_q + RetryW'(1);
               state_d = S_DRIVE;
            end else begin
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      j_d         = (state_d == S_DRIVE) &&  target_d;
      k_d         = (state_d == S_DRIVE) && !target_d;
      done_d      = (state_d == S_DONE);
      err_d       = (state_d == S_ERR);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         target_q    <= 1'b0;
         timer_q     <= '0;
         retry_q     <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         j_q         <= 1'b0;
         k_q         <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         j_q         <= j_d;
         k_q         <= k_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign busy_o      = busy_q;
   assign j_o         = j_q;
   assign k_o         = k_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_onoff_cmd_driver.sv
// Scoreboard bench for onoff_cmd_driver with a J/K follower model and a forceable status.
module tb_onoff_cmd_driver;

   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned RETRIES = 2;
`ifdef ONOFF_STATUS_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int kind;
      int lat;
      int jn;
      int kn;
      int gap;
   } exp_t;

   exp_t sb[$];

   logic clk = 1'b0;
   logic rst_n;
   logic req_valid, req_on, req_ready;
   logic status, j, k, busy, done, err;

   logic fol_q, fol_load, fol_init;
   int   fol_ign, fol_seen;
   logic use_force, force_val;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   onoff_cmd_driver #(.TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_on_i    (req_on),
      .req_ready_o (req_ready),
      .status_i    (status),
      .j_o         (j),
      .k_o         (k),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   // J/K follower that can be told to ignore its first fol_ign pulses.
   always @(posedge clk) begin
      if (fol_load) begin
         fol_q    <= fol_init;
         fol_seen <= 0;
      end else if (j || k) begin
         if (fol_seen < fol_ign) fol_seen <= fol_seen + 1;
         else                    fol_q    <= j;
      end
   end

   assign status = use_force ? force_val : fol_q;

   task automatic check(input string tag, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, req);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fol(input logic init, input int ign);
      fol_load = 1'b1;
      fol_init = init;
      fol_ign  = ign;
      next_cyc();
      fol_load = 1'b0;
      repeat (3) next_cyc();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, int'(req_ready), 1);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_jk"},    int'({j, k}), 0);
      check({tag, "_de"},    int'({done, err}), 0);
   endtask

   task automatic request(input logic on, input exp_t e);
      req_valid = 1'b1;
      req_on    = on;
      check("accept_ready", int'(req_ready), 1);
      sb.push_back(e);
      next_cyc();
      req_valid = 1'b0;
   endtask

   // Follows one transaction; c is the cycle count since accept.
   task automatic await_result(input int set_at);
      int   c    = 1;
      int   jn   = 0;
      int   kn   = 0;
      int   last = -1;
      int   gapv = 0;
      bit   fin  = 1'b0;
      exp_t e;
      while (!fin && c < 200) begin
         if (c == set_at) force_val = 1'b1;
         check("jk_excl", int'(j & k), 0);
         if (j || k) begin
            if (j) jn++;
            else   kn++;
            if (last >= 0) gapv = c - last;
            last = c;
         end
         if (done || err) begin
            fin = 1'b1;
            e = sb.pop_front();
            check("kind", done ? K_DONE : K_ERR, e.kind);
            check("both_de", int'(done & err), 0);
            check("latency", c, e.lat);
            check("j_pulses", jn, e.jn);
            check("k_pulses", kn, e.kn);
            check("pulse_gap", gapv, e.gap);
         end else begin
            next_cyc();
            c++;
         end
      end
      if (!fin) check("result_timeout", 0, 1);
      next_cyc();
      check_idle("post");
   endtask

   initial begin
      exp_t dummy;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_on    = 1'b0;
      use_force = 1'b0;
      force_val = 1'b0;
      fol_load  = 1'b1;
      fol_init  = 1'b0;
      fol_ign   = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;
      set_fol(1'b0, 0);

      // Nominal ON via j pulse.
      request(1'b1, exp_t'{K_DONE, 3 + SYNC_LAT, 1, 0, 0});
      await_result(-1);

      // Already ON: immediate done, no pulse.
      request(1'b1, exp_t'{K_DONE, 1, 0, 0, 0});
      await_result(-1);

      // Nominal OFF via k pulse.
      request(1'b0, exp_t'{K_DONE, 3 + SYNC_LAT, 0, 1, 0});
      await_result(-1);

      // Status stuck at 0: three pulses, then err.
      use_force = 1'b1;
      force_val = 1'b0;
      repeat (3) next_cyc();
      request(1'b1, exp_t'{K_ERR, 28, 3, 0, 9});
      await_result(-1);

      // Follower ignores first k pulse.
      use_force = 1'b0;
      set_fol(1'b1, 1);
      request(1'b0, exp_t'{K_DONE, 12 + SYNC_LAT, 0, 2, 9});
      await_result(-1);

      // Match arrives exactly as the timer reaches zero.
      use_force = 1'b1;
      force_val = 1'b0;
      repeat (3) next_cyc();
      request(1'b1, exp_t'{K_DONE, 10, 1, 0, 0});
      await_result(9 - SYNC_LAT);

      // Reset during WAIT with requests held while busy.
      force_val = 1'b0;
      repeat (3) next_cyc();
      request(1'b1, exp_t'{K_DONE, 0, 0, 0, 0});
      req_valid = 1'b1;
      req_on    = 1'b0;
      repeat (2) begin
         next_cyc();
         check("held_busy",  int'(busy), 1);
         check("held_ready", int'(req_ready), 0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("mid_rst");
      dummy = sb.pop_front();
      next_cyc();
      req_valid = 1'b0;
      rst_n     = 1'b1;
      repeat (2) begin
         next_cyc();
         check_idle("after_rst");
      end

      // Fresh request after reset.
      use_force = 1'b0;
      set_fol(1'b0, 0);
      request(1'b1, exp_t'{K_DONE, 3 + SYNC_LAT, 1, 0, 0});
      await_result(-1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
